hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Issue-control scoreboard for the LC-3b pipelined decode stage.
- Tracks in-flight writes to each of R0-R7 and to the condition codes.
- Holds an instruction in decode while any source register or CC it reads is still pending, so register-file and CC reads never return stale data.
- Sits beside the decode stage. It consumes decoded register fields plus the retire events from writeback, and drives the decode stall.

Parameters:
- CNT_W, 2, width of each pending-write counter; at most 2^CNT_W-1 in-flight writes per target.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all counters and err
- dec_valid  in  1  decode holds a valid instruction
- dec_src_a  in  3  first source register (ir[8:6])
- dec_src_a_used  in  1  instruction reads dec_src_a
- dec_src_b  in  3  second source register (selected ir[11:9] or ir[2:0])
- dec_src_b_used  in  1  instruction reads dec_src_b
- dec_reads_cc  in  1  instruction reads CC (BR)
- dec_dest  in  3  destination register (ir[11:9] or R7)
- dec_writes_reg  in  1  instruction writes dec_dest
- dec_sets_cc  in  1  instruction updates CC
- pipe_stall  in  1  downstream freeze; decode cannot advance
- flush  in  1  squash instruction currently in decode
- ret_valid  in  1  an issued instruction retires this cycle (also when squashed later)
- ret_dest  in  3  its destination register
- ret_writes_reg  in  1  it was counted against ret_dest at issue
- ret_sets_cc  in  1  it was counted against CC at issue
- stall  out  1  hold decode (hazard)
- issue  out  1  instruction leaves decode and is recorded this cycle
- reg_pending  out  8  bit i = counter[i] != 0
- cc_pending  out  1  CC counter != 0
- err  out  1  sticky: retire with zero counter

Behaviour:
- State:
  - reg_cnt[0..7], each CNT_W bits.
  - cc_cnt, CNT_W bits.
  - err flag, 1 bit.
  - All are zero after reset. Reset overrides all other inputs in the same cycle.
- stall is combinational and asserts only when dec_valid=1 and any of the following holds:
  - dec_src_a_used and reg_cnt[dec_src_a] != 0
  - dec_src_b_used and reg_cnt[dec_src_b] != 0
  - dec_reads_cc and cc_cnt != 0
  - dec_writes_reg and reg_cnt[dec_dest] == max (saturation guard)
  - dec_sets_cc and cc_cnt == max
- stall is 0 whenever dec_valid=0.
- issue = dec_valid & ~stall & ~pipe_stall & ~flush.
- No same-cycle bypass:
  - Hazard evaluation uses current counter values only.
  - A retire in cycle N releases a dependent instruction in cycle N+1.
- Counter update per target, every cycle:
  - inc = issue and instruction writes the target.
  - dec = ret_valid and retiring instruction writes the target.
  - inc and dec together: counter unchanged (net zero, including on the same register).
  - inc only: +1. Cannot overflow, because the saturation guard blocks issue at max.
  - dec only: -1. If the counter is already 0, it stays 0 and err is set to 1 until reset.
- The CC counter follows the same rules, using dec_sets_cc and ret_sets_cc.
- Self-dependency: an instruction with src == dest, where that register is free, issues. It is not stalled by its own write.
- flush:
  - Suppresses issue in the same cycle.
  - Does not alter counters; squashed in-flight instructions still present ret_valid so their counts drain.
  - Flush with ret_valid in the same cycle: the retire is applied normally.
- pipe_stall: counters still decrement on retire; no increments occur.
- R7 written by JSR/TRAP is tracked like any other register, via dec_dest = 7.

Decomposition:
- lc3b_types gains:
  - lc3b_reg (already present)
  - lc3b_sb_cnt, a CNT_W-bit counter typedef
  - a hazard-info struct grouping the src/dest/used/cc fields, filled from the control word alongside regfilemux/destmux selects
- One sub-module, sb_counter: a CNT_W up/down counter with inc, dec, clr, is_zero, is_max and an underflow pulse.
- Instantiate nine sb_counter copies (eight registers plus CC). Top level holds the stall logic and the err flag.

Test Plan:
1. RAW stall:
   - Issue ADD R1 <- R2,R3 (reg_cnt[1] becomes 1). Next cycle, ADD R4 <- R1,R5 with dec_valid=1 -> stall=1, issue=0.
   - ret_valid with ret_dest=1 in cycle N -> stall=0 and issue=1 in cycle N+1; reg_pending[1] returns to 0.
2. CC hazard: issue ADD with dec_sets_cc=1, then BR with dec_reads_cc=1 -> stall=1 until the CC retire, then issue=1 the following cycle.
3. Saturation (CNT_W=2): issue three writes to R2 with no retires -> reg_cnt[2]=3. A fourth write to R2 -> stall=1; one retire to R2 -> it issues next cycle.
4. Simultaneous issue and retire to R3 with count 1 -> count stays 1 and reg_pending[3]=1. Simultaneous issue to R3 and retire from R4 -> reg_cnt[3]=2, reg_cnt[4]=0.
5. flush with a hazard-free instruction -> issue=0 and counters unchanged. Retire with reg_cnt[6]=0 -> err=1, stays 1; reset -> err=0 and all counters 0.
6. Reset mid-operation with reg_cnt[1]=2 and cc_cnt=1 -> all reg_pending bits 0 and cc_pending=0 next cycle. A previously stalled reader issues immediately.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b decode types: register index, scoreboard counter and the
// hazard-info bundle decode fills from the control word.
package lc3b_types;

  localparam int unsigned SB_CNT_W = 2;

  typedef logic [2:0]          lc3b_reg;
  typedef logic [SB_CNT_W-1:0] lc3b_sb_cnt;

  typedef struct packed {
    lc3b_reg src_a;
    logic    src_a_used;
    lc3b_reg src_b;
    logic    src_b_used;
    logic    reads_cc;
    lc3b_reg dest;
    logic    writes_reg;
    logic    sets_cc;
  } lc3b_hazard_info;

  function automatic logic [7:0] reg_onehot(input lc3b_reg r);
    reg_onehot = 8'b1 << r;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one scoreboard target.
//   clr       : synchronous clear
//   inc / dec : issue / retire against this target (both together = no change)
//   is_zero   : no writes in flight
//   is_max    : counter saturated, further issues must be held
//   underflow : retire seen while already zero (count held at zero)
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic is_zero,
  output logic is_max,
  output logic underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign is_zero   = (cnt_q == '0);
  assign is_max    = (cnt_q == '1);
  assign underflow = dec & ~inc & is_zero & ~clr;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !is_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && !is_zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue scoreboard: holds an instruction while any register or
// CC it reads has an in-flight write, or while its write target is saturated.
//   dec_*  : decoded fields of the instruction in decode
//   ret_*  : retire (or squashed drain) event from writeback
//   stall / issue : decode hold / instruction recorded this cycle
//   reg_pending / cc_pending : nonzero-counter flags; err : sticky underflow
module hazard_scoreboard
  import lc3b_types::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic [2:0] dec_src_a,
  input  logic       dec_src_a_used,
  input  logic [2:0] dec_src_b,
  input  logic       dec_src_b_used,
  input  logic       dec_reads_cc,
  input  logic [2:0] dec_dest,
  input  logic       dec_writes_reg,
  input  logic       dec_sets_cc,
  input  logic       pipe_stall,
  input  logic       flush,
  input  logic       ret_valid,
  input  logic [2:0] ret_dest,
  input  logic       ret_writes_reg,
  input  logic       ret_sets_cc,
  output logic       stall,
  output logic       issue,
  output logic [7:0] reg_pending,
  output logic       cc_pending,
  output logic       err
);

  lc3b_hazard_info hz;

  logic [7:0] reg_zero;
  logic [7:0] reg_max;
  logic [7:0] reg_underflow;
  logic [7:0] reg_inc;
  logic [7:0] reg_dec;
  logic       cc_zero;
  logic       cc_max;
  logic       cc_underflow;
  logic       cc_inc;
  logic       cc_dec;
  logic       hazard;

  always_comb begin
    hz.src_a      = dec_src_a;
    hz.src_a_used = dec_src_a_used;
    hz.src_b      = dec_src_b;
    hz.src_b_used = dec_src_b_used;
    hz.reads_cc   = dec_reads_cc;
    hz.dest       = dec_dest;
    hz.writes_reg = dec_writes_reg;
    hz.sets_cc    = dec_sets_cc;
  end

  // Only current counter state is consulted, so a same-cycle retire never
  // releases a reader and an instruction's own write never stalls it.
  always_comb begin
    hazard = (hz.src_a_used & ~reg_zero[hz.src_a])
           | (hz.src_b_used & ~reg_zero[hz.src_b])
           | (hz.reads_cc   & ~cc_zero)
           | (hz.writes_reg &  reg_max[hz.dest])
           | (hz.sets_cc    &  cc_max);
    stall  = dec_valid & hazard;
    issue  = dec_valid & ~stall & ~pipe_stall & ~flush;
  end

  always_comb begin
    reg_inc = (issue && hz.writes_reg) ? reg_onehot(hz.dest) : '0;
    reg_dec = (ret_valid && ret_writes_reg) ? reg_onehot(ret_dest) : '0;
    cc_inc  = issue & hz.sets_cc;
    cc_dec  = ret_valid & ret_sets_cc;
  end

  for (genvar i = 0; i < 8; i++) begin : g_reg_cnt
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk      (clk),
      .clr      (reset),
      .inc      (reg_inc[i]),
      .dec      (reg_dec[i]),
      .is_zero  (reg_zero[i]),
      .is_max   (reg_max[i]),
      .underflow(reg_underflow[i])
    );
  end

  sb_counter #(
    .CNT_W(CNT_W)
  ) u_cc_cnt (
    .clk      (clk),
    .clr      (reset),
    .inc      (cc_inc),
    .dec      (cc_dec),
    .is_zero  (cc_zero),
    .is_max   (cc_max),
    .underflow(cc_underflow)
  );

  assign reg_pending = ~reg_zero;
  assign cc_pending  = ~cc_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((|reg_underflow) || cc_underflow) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       dec_valid;
  logic [2:0] dec_src_a;
  logic       dec_src_a_used;
  logic [2:0] dec_src_b;
  logic       dec_src_b_used;
  logic       dec_reads_cc;
  logic [2:0] dec_dest;
  logic       dec_writes_reg;
  logic       dec_sets_cc;
  logic       pipe_stall;
  logic       flush;
  logic       ret_valid;
  logic [2:0] ret_dest;
  logic       ret_writes_reg;
  logic       ret_sets_cc;
  logic       stall;
  logic       issue;
  logic [7:0] reg_pending;
  logic       cc_pending;
  logic       err;

  hazard_scoreboard #(.CNT_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_src_a     (dec_src_a),
    .dec_src_a_used(dec_src_a_used),
    .dec_src_b     (dec_src_b),
    .dec_src_b_used(dec_src_b_used),
    .dec_reads_cc  (dec_reads_cc),
    .dec_dest      (dec_dest),
    .dec_writes_reg(dec_writes_reg),
    .dec_sets_cc   (dec_sets_cc),
    .pipe_stall    (pipe_stall),
    .flush         (flush),
    .ret_valid     (ret_valid),
    .ret_dest      (ret_dest),
    .ret_writes_reg(ret_writes_reg),
    .ret_sets_cc   (ret_sets_cc),
    .stall         (stall),
    .issue         (issue),
    .reg_pending   (reg_pending),
    .cc_pending    (cc_pending),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       issue;
    logic [7:0] pend;
    logic       cc;
    logic       err;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned m_cnt[8];
  int unsigned m_cc;
  bit          m_err;

  localparam int unsigned MAXC = 3;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    bit h;
    if (!dec_valid) return 1'b0;
    h = (dec_src_a_used && m_cnt[dec_src_a] != 0)
     || (dec_src_b_used && m_cnt[dec_src_b] != 0)
     || (dec_reads_cc   && m_cc != 0)
     || (dec_writes_reg && m_cnt[dec_dest] == MAXC)
     || (dec_sets_cc    && m_cc == MAXC);
    return h;
  endfunction

  // Expected outputs for the current cycle are queued before the edge,
  // compared mid-cycle, then the model advances with the same inputs.
  task automatic tick();
    exp_t e;
    exp_t x;
    bit   inc;
    bit   dc;
    e.stall = m_stall();
    e.issue = dec_valid && !e.stall && !pipe_stall && !flush;
    for (int i = 0; i < 8; i++) e.pend[i] = (m_cnt[i] != 0);
    e.cc  = (m_cc != 0);
    e.err = m_err;
    sbq.push_back(e);
    @(negedge clk);
    x = sbq.pop_front();
    check("stall", 8'(stall), 8'(x.stall));
    check("issue", 8'(issue), 8'(x.issue));
    check("reg_pending", reg_pending, x.pend);
    check("cc_pending", 8'(cc_pending), 8'(x.cc));
    check("err", 8'(err), 8'(x.err));
    if (reset) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_cc  = 0;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        inc = e.issue && dec_writes_reg && (int'(dec_dest) == i);
        dc  = ret_valid && ret_writes_reg && (int'(ret_dest) == i);
        if (inc && !dc) m_cnt[i]++;
        else if (dc && !inc) begin
          if (m_cnt[i] == 0) m_err = 1'b1;
          else m_cnt[i]--;
        end
      end
      inc = e.issue && dec_sets_cc;
      dc  = ret_valid && ret_sets_cc;
      if (inc && !dc) m_cc++;
      else if (dc && !inc) begin
        if (m_cc == 0) m_err = 1'b1;
        else m_cc--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_src_a = 0; dec_src_a_used = 0; dec_src_b = 0;
    dec_src_b_used = 0; dec_reads_cc = 0; dec_dest = 0; dec_writes_reg = 0;
    dec_sets_cc = 0; pipe_stall = 0; flush = 0;
    ret_valid = 0; ret_dest = 0; ret_writes_reg = 0; ret_sets_cc = 0;
  endtask

  task automatic set_instr(input logic [2:0] sa, input logic sau, input logic [2:0] sb,
                           input logic sbu, input logic rcc, input logic [2:0] d,
                           input logic wr, input logic scc);
    dec_valid = 1; dec_src_a = sa; dec_src_a_used = sau; dec_src_b = sb;
    dec_src_b_used = sbu; dec_reads_cc = rcc; dec_dest = d;
    dec_writes_reg = wr; dec_sets_cc = scc;
  endtask

  task automatic set_ret(input logic [2:0] rd, input logic rw, input logic rs);
    ret_valid = 1; ret_dest = rd; ret_writes_reg = rw; ret_sets_cc = rs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_cc  = 0;
    m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    check("rst_pending", reg_pending, 8'h00);
    check("rst_cc", 8'(cc_pending), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    tick();

    // RAW: ADD R1 <- R2,R3 then ADD R4 <- R1,R5
    set_instr(3'd2, 1, 3'd3, 1, 0, 3'd1, 1, 0);
    tick();
    set_instr(3'd1, 1, 3'd5, 1, 0, 3'd4, 1, 0);
    #1;
    check("raw_stall", 8'(stall), 8'd1);
    check("raw_no_issue", 8'(issue), 8'd0);
    tick();
    set_ret(3'd1, 1, 0);
    #1;
    check("raw_no_bypass", 8'(stall), 8'd1);
    tick();
    ret_valid = 0;
    #1;
    check("raw_release_stall", 8'(stall), 8'd0);
    check("raw_release_issue", 8'(issue), 8'd1);
    check("raw_r1_clear", reg_pending, 8'h00);
    tick();
    idle();

    // CC hazard
    set_instr(3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 1);
    tick();
    set_instr(3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 0);
    #1;
    check("cc_stall", 8'(stall), 8'd1);
    check("cc_pending", 8'(cc_pending), 8'd1);
    tick();
    set_ret(3'd0, 1, 1);
    #1;
    check("cc_no_bypass", 8'(stall), 8'd1);
    tick();
    ret_valid = 0;
    #1;
    check("cc_release_issue", 8'(issue), 8'd1);
    check("cc_drained", 8'(cc_pending), 8'd0);
    tick();
    idle();

    // Saturation on R2
    set_instr(3'd0, 0, 3'd0, 0, 0, 3'd2, 1, 0);
    repeat (3) tick();
    #1;
    check("sat_stall", 8'(stall), 8'd1);
    check("sat_pending2", 8'(reg_pending[2]), 8'd1);
    tick();
    set_ret(3'd2, 1, 0);
    tick();
    ret_valid = 0;
    #1;
    check("sat_release_issue", 8'(issue), 8'd1);
    tick();
    idle();

    // Simultaneous issue / retire on R3, then R3 issue with R4 retire
    set_instr(3'd0, 0, 3'd0, 0, 0, 3'd3, 1, 0);
    tick();
    set_ret(3'd3, 1, 0);
    #1;
    check("net0_issue", 8'(issue), 8'd1);
    tick();
    check("net0_r3_pending", 8'(reg_pending[3]), 8'd1);
    set_ret(3'd4, 1, 0);
    tick();
    check("mix_r4_clear", 8'(reg_pending[4]), 8'd0);
    idle();
    set_ret(3'd3, 1, 0);
    tick();
    check("mix_r3_was_two", 8'(reg_pending[3]), 8'd1);
    tick();
    check("mix_r3_drained", 8'(reg_pending[3]), 8'd0);
    idle();

    // Flush, underflow error, reset
    set_instr(3'd6, 1, 3'd0, 0, 0, 3'd5, 1, 0);
    flush = 1;
    #1;
    check("flush_no_issue", 8'(issue), 8'd0);
    check("flush_no_stall", 8'(stall), 8'd0);
    tick();
    idle();
    check("flush_r5_unchanged", 8'(reg_pending[5]), 8'd0);
    set_ret(3'd6, 1, 0);
    tick();
    idle();
    check("underflow_err", 8'(err), 8'd1);
    tick();
    check("err_sticky", 8'(err), 8'd1);
    reset = 1;
    tick();
    reset = 0;
    check("err_cleared", 8'(err), 8'd0);
    check("rst2_pending", reg_pending, 8'h00);

    // Reset mid-operation releases a stalled reader
    set_instr(3'd0, 0, 3'd0, 0, 0, 3'd1, 1, 1);
    tick();
    set_instr(3'd0, 0, 3'd0, 0, 0, 3'd1, 1, 0);
    tick();
    set_instr(3'd1, 1, 3'd0, 0, 1, 3'd7, 1, 0);
    #1;
    check("mid_stall", 8'(stall), 8'd1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("mid_pending", reg_pending, 8'h00);
    check("mid_cc", 8'(cc_pending), 8'd0);
    check("mid_issue", 8'(issue), 8'd1);
    tick();
    idle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      dec_valid      = 1'($urandom_range(0, 3) != 0);
      dec_src_a      = 3'($urandom_range(0, 7));
      dec_src_a_used = 1'($urandom_range(0, 1));
      dec_src_b      = 3'($urandom_range(0, 7));
      dec_src_b_used = 1'($urandom_range(0, 1));
      dec_reads_cc   = 1'($urandom_range(0, 3) == 0);
      dec_dest       = 3'($urandom_range(0, 7));
      dec_writes_reg = 1'($urandom_range(0, 3) != 0);
      dec_sets_cc    = 1'($urandom_range(0, 1));
      pipe_stall     = 1'($urandom_range(0, 5) == 0);
      flush          = 1'($urandom_range(0, 7) == 0);
      ret_valid      = 1'($urandom_range(0, 1));
      ret_dest       = 3'($urandom_range(0, 7));
      ret_writes_reg = 1'($urandom_range(0, 1));
      ret_sets_cc    = 1'($urandom_range(0, 2) == 0);
      reset          = 1'($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 0;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
